// File: rtl/ccff_ctrl_pkg.sv
// Shared definitions for the ccff chain loader: FSM states, default geometry
// and a small sizing helper.
package ccff_ctrl_pkg;

  localparam int DEF_CHAIN_LEN = 8;
  localparam int DEF_DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host-side handshake bundle of the ccff chain loader.
// Readback signals exist only when CCFF_READBACK_EN is defined.
interface ccff_chain_loader_if
  import ccff_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              busy;
  logic              done;
`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;
`endif

  modport master (
    output start, cfg_data, cfg_valid,
    input  cfg_ready, busy, done
`ifdef CCFF_READBACK_EN
    , input rb_data, rb_valid
`endif
  );

  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, busy, done
`ifdef CCFF_READBACK_EN
    , output rb_data, rb_valid
`endif
  );

endinterface

// File: rtl/ccff_serializer.sv
// Word shift register and word-bit counter feeding the chain head, LSB first.
module ccff_serializer
  import ccff_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       prog_clk,
  input  logic                       prog_reset,
  input  logic                       load,
  input  logic                       shift,
  input  logic [DATA_W-1:0]          data,
  input  logic [$clog2(DATA_W+1)-1:0] nbits,
  output logic                       head_bit,
  output logic                       last_bit
);

  localparam int WB_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr;
  logic [WB_W-1:0]   cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= nbits;
    end else if (shift && cnt != '0) begin
      sr  <= sr >> 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign head_bit = sr[0];
  assign last_bit = (cnt == WB_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a CHAIN_LEN-bit configuration chain from DATA_W-bit host words.
// Optional readback of the prior chain contents: define CCFF_READBACK_EN.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  ccff_chain_loader_if.slave  host,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(DATA_W + 1);

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic              cfg_ready_q;
  logic              shift_en_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              shift;
  logic [WB_W-1:0]   word_bits;
  logic              head_bit;
  logic              last_bit;

  assign accept    = cfg_ready_q & host.cfg_valid;
  assign shift     = shift_en_q && (remaining != '0);
  assign word_bits = WB_W'(min_int(DATA_W, int'(remaining)));

  ccff_serializer #(.DATA_W(DATA_W)) u_ser (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (accept),
    .shift      (shift),
    .data       (host.cfg_data),
    .nbits      (word_bits),
    .head_bit   (head_bit),
    .last_bit   (last_bit)
  );

  // Outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      cfg_ready_q <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.start) begin
            state       <= ST_LOAD;
            remaining   <= CNT_W'(CHAIN_LEN);
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            state       <= ST_SHIFT;
            cfg_ready_q <= 1'b0;
            shift_en_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (remaining != '0) remaining <= remaining - 1'b1;
          if (last_bit || remaining == '0) begin
            shift_en_q <= 1'b0;
            if (remaining <= CNT_W'(1)) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state       <= ST_LOAD;
              cfg_ready_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign host.cfg_ready = cfg_ready_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign ccff_shift_en  = shift_en_q;
  assign ccff_head      = shift_en_q & head_bit;

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] rb_acc;
  logic [DATA_W-1:0] rb_next;
  logic [DATA_W-1:0] rb_data_q;
  logic [WB_W-1:0]   rb_idx;
  logic              rb_valid_q;

  // Tail bits land LSB first; unshifted upper bits stay zero from the clear.
  assign rb_next = rb_acc | (DATA_W'(ccff_tail) << rb_idx);

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      rb_acc     <= '0;
      rb_idx     <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (accept) begin
        rb_acc <= '0;
        rb_idx <= '0;
      end else if (shift) begin
        rb_acc <= rb_next;
        rb_idx <= rb_idx + 1'b1;
        if (last_bit) begin
          rb_data_q  <= rb_next;
          rb_valid_q <= 1'b1;
        end
      end
    end
  end

  assign host.rb_data  = rb_data_q;
  assign host.rb_valid = rb_valid_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized self-checking bench: two loaders (8- and 10-bit chains) against a
// cycle schedule derived from the loading rules, plus behavioural chain models.
module tb_ccff_chain_loader;

  localparam int CL_A = 8;
  localparam int CL_B = 10;
  localparam int DW   = 8;

  typedef struct packed {
    logic busy;
    logic ready;
    logic sen;
    logic head;
    logic done;
  } outs_t;

  typedef struct {
    outs_t      o;
    logic       valid;
    logic [7:0] data;
    logic       rbv;
    logic [7:0] rbd;
  } step_t;

  typedef logic [7:0] word_arr_t [4];
  typedef int         stall_arr_t [4];

  logic       clk = 1'b0;
  logic       prog_reset = 1'b1;
  logic       start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] cfg_data = '0;

  int vectors = 0;
  int miscompares = 0;

  ccff_chain_loader_if #(.DATA_W(DW)) if_a ();
  ccff_chain_loader_if #(.DATA_W(DW)) if_b ();

  assign if_a.start     = start & ~sel;
  assign if_a.cfg_valid = cfg_valid & ~sel;
  assign if_a.cfg_data  = cfg_data;
  assign if_b.start     = start & sel;
  assign if_b.cfg_valid = cfg_valid & sel;
  assign if_b.cfg_data  = cfg_data;

  logic head_a, sen_a, head_b, sen_b;
  logic [CL_A-1:0] chain_a = '0;
  logic [CL_B-1:0] chain_b = '0;
  logic       preload_a = 1'b0;
  logic [7:0] preload_val = '0;

  ccff_chain_loader #(.CHAIN_LEN(CL_A), .DATA_W(DW)) dut_a (
    .prog_clk(clk), .prog_reset(prog_reset), .host(if_a),
    .ccff_head(head_a), .ccff_shift_en(sen_a), .ccff_tail(chain_a[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(CL_B), .DATA_W(DW)) dut_b (
    .prog_clk(clk), .prog_reset(prog_reset), .host(if_b),
    .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(chain_b[0])
  );

  always #5 clk = ~clk;

  // Chain models: head enters the far end, bit 0 is the tail flop.
  always @(posedge clk) begin
    if (preload_a)  chain_a <= preload_val;
    else if (sen_a) chain_a <= {head_a, chain_a[CL_A-1:1]};
    if (sen_b)      chain_b <= {head_b, chain_b[CL_B-1:1]};
  end

  outs_t obs_a, obs_b, obs;
  assign obs_a = {if_a.busy, if_a.cfg_ready, sen_a, head_a, if_a.done};
  assign obs_b = {if_b.busy, if_b.cfg_ready, sen_b, head_b, if_b.done};
  assign obs   = sel ? obs_b : obs_a;

  logic       obs_rbv;
  logic [7:0] obs_rbd;
`ifdef CCFF_READBACK_EN
  assign obs_rbv = sel ? if_b.rb_valid : if_a.rb_valid;
  assign obs_rbd = sel ? if_b.rb_data  : if_a.rb_data;
`else
  assign obs_rbv = 1'b0;
  assign obs_rbd = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t mk(input logic b, input logic r, input logic s,
                               input logic h, input logic d);
    return outs_t'({b, r, s, h, d});
  endfunction

  // Builds the expected cycle schedule of one load, drives it and compares.
  task automatic run_load(input bit s, input word_arr_t words, input stall_arr_t stalls,
                          input int reset_shift, input bit noisy_start,
                          output int done_cyc, output int shifts,
                          output int rb_cnt, output logic [7:0] rb_last);
    step_t sched[$];
    step_t r;
    int cl, rem, pos, n, wi, nshift;
    logic [CL_B-1:0] prior, newc, got;
    logic pend_v;
    logic [7:0] pend_d, rbd;

    cl = s ? CL_B : CL_A;
    prior = s ? chain_b : CL_B'(chain_a);
    newc = '0; rem = cl; pos = 0; wi = 0;
    pend_v = 1'b0; pend_d = '0;
    while (rem > 0) begin
      for (int k = 0; k < stalls[wi]; k++) begin
        r.o = mk(1, 1, 0, 0, 0); r.valid = 1'b0; r.data = 8'($urandom);
        r.rbv = pend_v; r.rbd = pend_d; pend_v = 1'b0;
        sched.push_back(r);
      end
      r.o = mk(1, 1, 0, 0, 0); r.valid = 1'b1; r.data = words[wi];
      r.rbv = pend_v; r.rbd = pend_d; pend_v = 1'b0;
      sched.push_back(r);
      n = (rem < DW) ? rem : DW;
      rbd = '0;
      for (int b = 0; b < n; b++) begin
        r.o = mk(1, 0, 1, words[wi][b], 0);
        r.valid = 1'($urandom); r.data = 8'($urandom);
        r.rbv = 1'b0; r.rbd = '0;
        sched.push_back(r);
        newc[pos+b] = words[wi][b];
        rbd[b] = prior[pos+b];
      end
      pend_v = 1'b1; pend_d = rbd;
      pos += n; rem -= n; wi++;
    end
    r.o = mk(1, 0, 0, 0, 1); r.valid = 1'b0; r.data = '0;
    r.rbv = pend_v; r.rbd = pend_d;
    sched.push_back(r);
    for (int k = 0; k < 2; k++) begin
      r.o = '0; r.valid = 1'b0; r.data = '0; r.rbv = 1'b0; r.rbd = '0;
      sched.push_back(r);
    end

    sel = s;
    vectors++;
    if (obs !== outs_t'('0)) begin
      miscompares++;
      $display("FAIL idle_before_start: got %b want %b", obs, 5'b0);
    end
    start = 1'b1; cfg_valid = 1'b0;
    tick();
    start = 1'b0;

    done_cyc = -1; shifts = 0; nshift = 0; rb_cnt = 0; rb_last = '0;
    foreach (sched[i]) begin
      r = sched[i];
      cfg_valid = r.valid;
      cfg_data  = r.data;
      start     = (noisy_start && r.o.busy) ? 1'($urandom) : 1'b0;
      if (obs.sen) shifts++;
      if (obs.done && done_cyc < 0) done_cyc = i + 1;
      if (obs_rbv) begin rb_cnt++; rb_last = obs_rbd; end
      if (r.o.sen) nshift++;
      vectors++;
      if (obs !== r.o) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got %b want %b (busy,ready,sen,head,done)", i + 1, obs, r.o);
      end
`ifdef CCFF_READBACK_EN
      vectors++;
      if (obs_rbv !== r.rbv) begin
        miscompares++;
        $display("FAIL rb_valid cycle %0d: got %b want %b", i + 1, obs_rbv, r.rbv);
      end
      if (r.rbv) begin
        vectors++;
        if (obs_rbd !== r.rbd) begin
          miscompares++;
          $display("FAIL rb_data cycle %0d: got %h want %h", i + 1, obs_rbd, r.rbd);
        end
      end
`endif
      if (reset_shift > 0 && r.o.sen && nshift == reset_shift) begin
        prog_reset = 1'b1;
        #1;
        vectors++;
        if (obs !== outs_t'('0) || obs_rbv !== 1'b0 || obs_rbd !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_mid_shift: got %b rb %b/%h want all zero", obs, obs_rbv, obs_rbd);
        end
        #2;
        prog_reset = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick();
          vectors++;
          if (obs !== outs_t'('0)) begin
            miscompares++;
            $display("FAIL after_abort cycle %0d: got %b want %b", k, obs, 5'b0);
          end
        end
        return;
      end
      tick();
    end
    start = 1'b0; cfg_valid = 1'b0;
    got = s ? chain_b : CL_B'(chain_a);
    vectors++;
    if (got !== newc) begin
      miscompares++;
      $display("FAIL chain_contents: got %h want %h", got, newc);
    end
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    #1;
    vectors++;
    if (obs_a !== outs_t'('0) || obs_b !== outs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b/%b want 00000/00000", obs_a, obs_b);
    end
`ifdef CCFF_READBACK_EN
    vectors++;
    if (if_a.rb_valid !== 1'b0 || if_a.rb_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rb: got %b/%h want 0/00", if_a.rb_valid, if_a.rb_data);
    end
`endif
    tick(); tick();
    #2 prog_reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    word_arr_t w = '{8'hA5, 8'h00, 8'h00, 8'h00};
    stall_arr_t st = '{0, 0, 0, 0};
    int dc, sh, rc; logic [7:0] rl;
    run_load(1'b0, w, st, 0, 1'b0, dc, sh, rc, rl);
    vectors++;
    if (dc !== 10 || sh !== 8) begin
      miscompares++;
      $display("FAIL a5_timing: got done@%0d shifts %0d want done@10 shifts 8", dc, sh);
    end
  endtask

  task automatic test_partial_word();
    word_arr_t w = '{8'hFF, 8'h02, 8'h00, 8'h00};
    stall_arr_t st = '{0, 0, 0, 0};
    int dc, sh, rc; logic [7:0] rl;
    run_load(1'b1, w, st, 0, 1'b0, dc, sh, rc, rl);
    vectors++;
    if (sh !== 10 || chain_b !== 10'h2FF) begin
      miscompares++;
      $display("FAIL partial_word: got shifts %0d chain %h want 10 / 2ff", sh, chain_b);
    end
  endtask

  task automatic test_stall();
    word_arr_t w = '{8'hA5, 8'h00, 8'h00, 8'h00};
    stall_arr_t st = '{3, 0, 0, 0};
    int dc, sh, rc; logic [7:0] rl;
    run_load(1'b0, w, st, 0, 1'b0, dc, sh, rc, rl);
    vectors++;
    if (dc !== 13 || sh !== 8) begin
      miscompares++;
      $display("FAIL stall_timing: got done@%0d shifts %0d want done@13 shifts 8", dc, sh);
    end
  endtask

  task automatic test_start_busy();
    word_arr_t w = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    stall_arr_t st = '{1, 2, 0, 0};
    int dc, sh, rc; logic [7:0] rl;
    run_load(1'b1, w, st, 0, 1'b1, dc, sh, rc, rl);
    vectors++;
    if (sh !== CL_B) begin
      miscompares++;
      $display("FAIL start_while_busy: got shifts %0d want %0d", sh, CL_B);
    end
  endtask

  task automatic test_reset_mid_shift();
    word_arr_t w = '{8'h96, 8'h00, 8'h00, 8'h00};
    stall_arr_t st = '{0, 0, 0, 0};
    int dc, sh, rc; logic [7:0] rl;
    run_load(1'b0, w, st, 4, 1'b0, dc, sh, rc, rl);
    vectors++;
    if (dc !== -1) begin
      miscompares++;
      $display("FAIL abort_no_done: got done@%0d want none", dc);
    end
    w[0] = 8'h3E;
    run_load(1'b0, w, st, 0, 1'b0, dc, sh, rc, rl);
    vectors++;
    if (chain_a !== 8'h3E) begin
      miscompares++;
      $display("FAIL reload_after_abort: got %h want 3e", chain_a);
    end
  endtask

  task automatic test_random();
    word_arr_t w;
    stall_arr_t st;
    int dc, sh, rc; logic [7:0] rl;
    bit s;
    for (int it = 0; it < 16; it++) begin
      s = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        w[k]  = 8'($urandom);
        st[k] = int'($urandom_range(0, 3));
      end
      run_load(s, w, st, 0, 1'($urandom), dc, sh, rc, rl);
      vectors++;
      if (sh !== (s ? CL_B : CL_A)) begin
        miscompares++;
        $display("FAIL random_shift_count iter %0d: got %0d want %0d", it, sh, s ? CL_B : CL_A);
      end
    end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback();
    word_arr_t w = '{8'hA5, 8'h00, 8'h00, 8'h00};
    stall_arr_t st = '{0, 0, 0, 0};
    int dc, sh, rc; logic [7:0] rl;
    sel = 1'b0;
    preload_val = 8'h3C; preload_a = 1'b1;
    tick();
    preload_a = 1'b0;
    run_load(1'b0, w, st, 0, 1'b0, dc, sh, rc, rl);
    vectors++;
    if (rc !== 1 || rl !== 8'h3C || chain_a !== 8'hA5) begin
      miscompares++;
      $display("FAIL readback: got %0d strobes data %h chain %h want 1 / 3c / a5", rc, rl, chain_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_partial_word();
    test_stall();
    test_start_busy();
    test_reset_mid_shift();
    test_random();
`ifdef CCFF_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of configuration flip-flops in the target ccff chain (must be >= 1).
REQ-002 Parameter DATA_W, default 8: width of host configuration words (must be >= 1).
REQ-003 prog_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 prog_reset  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin loading a full chain.
REQ-006 cfg_data  input  DATA_W  configuration word; bit 0 is shifted first.
REQ-007 cfg_valid  input  1  cfg_data valid.
REQ-008 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-009 ccff_head  output  1  serial bit driven into the chain head.
REQ-010 ccff_shift_en  output  1  chain flip-flops capture ccff_head on the next prog_clk edge.
REQ-011 ccff_tail  input  1  serial bit leaving the chain tail.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the last chain bit has been shifted.
REQ-014 rb_data  output  DATA_W  readback word; present only with CCFF_READBACK_EN.
REQ-015 rb_valid  output  1  one-cycle readback strobe with no backpressure; present only with CCFF_READBACK_EN.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE: start=1 -> LOAD; remaining-bit counter set to CHAIN_LEN. start is ignored in every other state.
REQ-018 LOAD: cfg_ready=1. On cfg_valid&cfg_ready, capture cfg_data, set word-bit count = min(DATA_W, remaining), and go to SHIFT. cfg_valid=0 stalls in LOAD with ccff_shift_en=0.
REQ-019 SHIFT: ccff_shift_en=1 every cycle; ccff_head = shift-register bit 0; shift register moves right by 1; remaining and word-bit counts decrement.
REQ-020 SHIFT exit: after the word's last bit, go to DONE if remaining==0, else to LOAD.
REQ-021 Final partial word: only the remaining low-order bits are shifted; the unused upper bits are discarded.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 cfg_ready=0 and ccff_shift_en=0 outside LOAD and SHIFT respectively. ccff_head=0 whenever ccff_shift_en=0.
REQ-024 Timing (CHAIN_LEN=8, DATA_W=8, cfg_valid held high): start at cycle 0; LOAD at cycle 1; shift_en at cycles 2-9; done at cycle 10. Each word costs 1 LOAD cycle plus one cycle per bit.
REQ-025 Counter width is clog2(CHAIN_LEN+1). Counters never wrap: no shift occurs with remaining==0.

Reset
REQ-026 On prog_reset: state=IDLE, counters=0, shift register=0, and every output = 0 (including rb_data and rb_valid).
REQ-027 Reset during LOAD or SHIFT aborts the load immediately, with no done pulse; the chain holds a partial shift and a new start is required.

Configuration
REQ-028 With CCFF_READBACK_EN defined: in every SHIFT cycle, ccff_tail is sampled into a readback register LSB-first. rb_data/rb_valid are asserted the cycle after each word's last shift; a partial final word is zero-padded in its upper bits. Over one load, the host receives the prior chain contents.
REQ-029 Without CCFF_READBACK_EN: the rb_data and rb_valid ports, the readback register and the associated logic are absent, and ccff_tail is unused.

Structure
REQ-030 Package ccff_ctrl_pkg holds the FSM state enum and the default values of CHAIN_LEN and DATA_W.
REQ-031 Sub-module ccff_serializer holds the word shift register and the word-bit counter. The FSM and the remaining-bit counter stay in ccff_chain_loader.

Verification
REQ-032 CHAIN_LEN=8, DATA_W=8, word 0xA5 -> ccff_head sequence 1,0,1,0,0,1,0,1 on cycles 2-9; done at cycle 10; busy high in cycles 1-10.
REQ-033 CHAIN_LEN=10, DATA_W=8, words 0xFF then 0x02 -> 8 ones, LOAD cycle, then 0,1; exactly 10 shift_en cycles; second word bits 7:2 never appear.
REQ-034 cfg_valid low for 3 cycles in LOAD -> shift_en stays low for those 3 cycles; bit order is unchanged; done is delayed by 3 cycles.
REQ-035 prog_reset asserted at the 4th shift cycle -> all outputs 0 in the same cycle; no done pulse; a following start reloads the chain fully.
REQ-036 start pulsed while busy -> ignored, with exactly CHAIN_LEN shifts and one done pulse.
REQ-037 CCFF_READBACK_EN, chain model preloaded with 0x3C -> after loading 0xA5, rb_data=0x3C with a single rb_valid, and the chain model holds 0xA5.
